// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and address mapping for the MEM-stage SRAM controller
//
// Purpose: controller state encoding, default SRAM base address and the
// byte-address to SRAM-word mapping used by mem_stage_sram_ctrl.
// Ports: none (package).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } mem_state_t;

    localparam logic [31:0] MEM_BASE_ADDR = 32'd1024;

    // Word index of a byte address relative to the SRAM base, mod 2^32.
    // Bits [1:0] of the offset are dropped: accesses are word-aligned only.
    // The caller truncates the result to its SRAM word width.
    function automatic logic [31:0] map_addr(input logic [31:0] byte_addr,
                                             input logic [31:0] base = MEM_BASE_ADDR);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_half_seq.sv
// rtl/sram_half_seq.sv - per-half access timer with last-cycle strobe and WE_N shaping
//
// Purpose: counts the cycles one 16-bit half is held on the SRAM pins and
// tells the controller when the half ends and what WE_N must be next cycle.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   active     controller is in a LOW or HIGH half
//   high_half  current half is the high half
//   write      current access is a store
//   last       this is the final cycle of the current half
//   we_n_next  value WE_N must take on the following cycle
module sram_half_seq #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic high_half,
    input  logic write,
    output logic last,
    output logic we_n_next
);

    logic [3:0] count;
    logic [3:0] last_idx;

    // The high half opens with a WE_N-high gap cycle; with single-cycle
    // halves it is stretched by one cycle so the strobe still gets a cycle.
    assign last_idx  = (high_half && ACCESS_CYCLES == 1) ? 4'd1 : 4'(ACCESS_CYCLES - 1);
    assign last      = active && (count == last_idx);

    // Strobe stays low through a write half and lifts on its final cycle,
    // which yields the gap at the start of HIGH and the release into DONE.
    assign we_n_next = ~(write & ~last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (!active || last) begin
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage controller doing 32-bit loads/stores as two 16-bit SRAM accesses
//
// Purpose: consumes the execute-stage address/data, runs the low then high
// half access on an asynchronous 16-bit SRAM, and holds ready low while busy
// so the pipeline can freeze on ~ready.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN    load / store request, held until ready
//   ALU_result, Val_Rm    byte address, store data
//   read_data             load result, valid when ready after a load
//   ready                 no access pending or access completing this cycle
//   SRAM_ADDR             half-word address (registered)
//   SRAM_WE_N             active-low write strobe (registered)
//   SRAM_DQ_out/_oe/_in   pad write data, pad drive enable, pad read data
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = MEM_BASE_ADDR,
    parameter int          SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic [15:0]        SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [15:0]        SRAM_DQ_in
);

    mem_state_t         state;
    logic               op_write;
    logic [31:0]        data_q;
    logic [SRAM_AW-2:0] word_q;
    logic [SRAM_AW-2:0] word_in;
    logic               req;
    logic               active;
    logic               half_last;
    logic               we_n_next;

    assign word_in = (SRAM_AW-1)'(map_addr(ALU_result, BASE_ADDR));
    assign req     = MEM_R_EN | MEM_W_EN;
    assign active  = (state == LOW) || (state == HIGH);

    // Combinational in IDLE so an idle pipeline never stalls, and a fresh
    // request freezes it in the very cycle it appears.
    assign ready   = ((state == IDLE) && !req) || (state == DONE);

    sram_half_seq #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_half_seq (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .high_half(state == HIGH),
        .write    (op_write),
        .last     (half_last),
        .we_n_next(we_n_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            read_data   <= 32'd0;
            SRAM_ADDR   <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_DQ_out <= 16'd0;
            op_write    <= 1'b0;
            data_q      <= 32'd0;
            word_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Pins are registered, so the low half is set up
                        // on this edge and is live from the first LOW cycle.
                        op_write    <= MEM_W_EN;
                        data_q      <= Val_Rm;
                        word_q      <= word_in;
                        SRAM_ADDR   <= {word_in, 1'b0};
                        SRAM_WE_N   <= ~MEM_W_EN;
                        SRAM_DQ_oe  <= MEM_W_EN;
                        SRAM_DQ_out <= Val_Rm[15:0];
                        state       <= LOW;
                    end
                end
                LOW: begin
                    SRAM_WE_N <= we_n_next;
                    if (half_last) begin
                        if (!op_write) begin
                            read_data[15:0] <= SRAM_DQ_in;
                        end
                        SRAM_ADDR   <= {word_q, 1'b1};
                        SRAM_DQ_out <= data_q[31:16];
                        state       <= HIGH;
                    end
                end
                HIGH: begin
                    SRAM_WE_N <= we_n_next;
                    if (half_last) begin
                        if (!op_write) begin
                            read_data[31:16] <= SRAM_DQ_in;
                        end
                        SRAM_DQ_oe <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not sampled here: the pipeline advances
                    // on this edge and presents its next request in IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - self-checking bench for mem_stage_sram_ctrl against a transaction-level model
module tb_mem_stage_sram_ctrl;

    localparam int AC = 2;
    localparam int L  = 2 * AC + 1 + ((AC == 1) ? 1 : 0);

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, Val_Rm;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] dq_in = 16'h0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(
        .ACCESS_CYCLES(AC),
        .BASE_ADDR    (32'd1024),
        .SRAM_AW      (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_result (ALU_result),
        .Val_Rm     (Val_Rm),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_oe (SRAM_DQ_oe),
        .SRAM_DQ_in (dq_in)
    );

    // Pin-level SRAM: written whenever the strobe is low at a clock edge.
    logic [15:0] sram [logic [17:0]];
    // Transaction-level memory image keyed by 32-bit word index.
    logic [31:0] ref_mem [int unsigned];

    int n_tests = 0;
    int n_fail  = 0;

    bit          chk_en = 1'b0;
    bit          chk_addr = 1'b0;
    bit          chk_rd = 1'b0;
    logic        exp_ready = 1'b1;
    logic        exp_we_n = 1'b1;
    logic        exp_oe = 1'b0;
    logic [17:0] exp_addr = 18'd0;
    logic [15:0] exp_dq = 16'd0;
    logic [31:0] exp_rd = 32'd0;

    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        return sram.exists(a) ? sram[a] : 16'h0;
    endfunction

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return off[18:2];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!SRAM_WE_N) sram[SRAM_ADDR] = SRAM_DQ_out;
    end

    always @(negedge clk) begin
        dq_in = sram_rd(SRAM_ADDR);
    end

    // Per-cycle compare against the model's expectations.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ready", 32'(ready), 32'(exp_ready));
            check("we_n", 32'(SRAM_WE_N), 32'(exp_we_n));
            check("oe", 32'(SRAM_DQ_oe), 32'(exp_oe));
            if (exp_oe) check("dq_out", 32'(SRAM_DQ_out), 32'(exp_dq));
            if (chk_addr) check("addr", 32'(SRAM_ADDR), 32'(exp_addr));
            if (chk_rd) check("read_data", read_data, exp_rd);
        end
    end

    task automatic set_idle();
        exp_ready = 1'b1;
        exp_we_n  = 1'b1;
        exp_oe    = 1'b0;
        chk_addr  = 1'b0;
        chk_rd    = 1'b1;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One access, cycle t=0 is the first cycle the request is visible.
    task automatic do_access(input bit w, input bit r, input logic [31:0] a,
                             input logic [31:0] d, output int lat);
        logic [16:0] wd;
        wd  = word_of(a);
        lat = -1;
        MEM_W_EN   = w;
        MEM_R_EN   = r;
        ALU_result = a;
        Val_Rm     = d;
        for (int t = 0; t <= L; t++) begin
            if (t == 0) begin
                exp_ready = 1'b0;
                exp_we_n  = 1'b1;
                exp_oe    = 1'b0;
                chk_addr  = 1'b0;
                chk_rd    = 1'b1;
            end else if (t < L) begin
                exp_ready = 1'b0;
                exp_addr  = {wd, 1'(t > AC)};
                exp_we_n  = !(w && t != AC + 1);
                exp_oe    = w;
                exp_dq    = (t > AC) ? d[31:16] : d[15:0];
                chk_addr  = 1'b1;
                chk_rd    = w;
            end else begin
                exp_ready = 1'b1;
                exp_we_n  = 1'b1;
                exp_oe    = 1'b0;
                chk_addr  = 1'b0;
                chk_rd    = 1'b1;
                if (!w) exp_rd = ref_mem.exists(int'(wd)) ? ref_mem[int'(wd)] : 32'h0;
            end
            @(negedge clk);
            if (ready && lat < 0) lat = t;
            @(posedge clk);
            #1;
        end
        if (w) ref_mem[int'(wd)] = d;
        MEM_W_EN = 1'b0;
        MEM_R_EN = 1'b0;
        set_idle();
    endtask

    initial begin
        int lat;
        int op;
        logic [31:0] a;

        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'd0;
        Val_Rm     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_oe", 32'(SRAM_DQ_oe), 32'd0);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_dq_out", 32'(SRAM_DQ_out), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        rst = 1'b0;

        // Idle pipeline.
        chk_en = 1'b1;
        idle(10);

        // Reset during the first LOW cycle of a store.
        chk_en     = 1'b0;
        MEM_W_EN   = 1'b1;
        ALU_result = 32'd1024;
        Val_Rm     = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        check("midop_we_low", 32'(SRAM_WE_N), 32'd0);
        rst = 1'b1;
        #1;
        check("midop_we_n", 32'(SRAM_WE_N), 32'd1);
        check("midop_oe", 32'(SRAM_DQ_oe), 32'd0);
        check("midop_ready_req", 32'(ready), 32'd0);
        MEM_W_EN = 1'b0;
        #1;
        check("midop_ready_idle", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midop_no_high", 32'(sram.exists(18'd1)), 32'd0);
        chk_en = 1'b1;
        idle(1);

        // Store 0xDEADBEEF at 1032.
        do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, lat);
        check("store_latency", 32'(lat), 32'd5);
        check("store_low", 32'(sram_rd(18'd4)), 32'h0000BEEF);
        check("store_high", 32'(sram_rd(18'd5)), 32'h0000DEAD);
        idle(1);

        // Load it back.
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, lat);
        check("load_latency", 32'(lat), 32'd5);
        check("load_data", read_data, 32'hDEADBEEF);
        idle(2);

        // Both enables: write wins, read_data untouched.
        do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, lat);
        check("conflict_low", 32'(sram_rd(18'd0)), 32'h00005678);
        check("conflict_high", 32'(sram_rd(18'd1)), 32'h00001234);
        check("conflict_rd", read_data, 32'hDEADBEEF);

        // Back-to-back store then load.
        do_access(1'b1, 1'b0, 32'd1036, 32'hA5A55A5A, lat);
        do_access(1'b0, 1'b1, 32'd1036, 32'h0, lat);
        check("b2b_load", read_data, 32'hA5A55A5A);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = $urandom();
            else a = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            do_access(op != 0, op != 1, a, $urandom(), lat);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- MEM-stage memory controller of the ARM pipeline; the consumer end of the execute-stage outputs.
- Takes the execute-stage ALU result as the byte address and the Rm value as store data.
- Performs each 32-bit load/store as two 16-bit accesses to an external asynchronous SRAM.
- Drops ready while busy; the pipeline uses ~ready as its freeze signal.

Parameters:
- ACCESS_CYCLES, 2, clock cycles each 16-bit half access is held on the SRAM pins (legal range 1..15).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM address width in 16-bit words.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- MEM_R_EN  in  1  load request, held until ready=1.
- MEM_W_EN  in  1  store request, held until ready=1.
- ALU_result  in  32  byte address from execute stage.
- Val_Rm  in  32  store data.
- read_data  out  32  load result; valid when ready=1 after a load.
- ready  out  1  1 = no access pending or access completing this cycle.
- SRAM_ADDR  out  SRAM_AW  SRAM half-word address.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_DQ_out  out  16  write data to pad.
- SRAM_DQ_oe  out  1  1 = drive SRAM_DQ_out onto the pad.
- SRAM_DQ_in  in  16  read data from pad.

Behaviour:
Reset:
- state=IDLE; read_data=0; SRAM_ADDR=0; SRAM_WE_N=1; SRAM_DQ_oe=0; SRAM_DQ_out=0; counter=0.
- Async reset mid-access aborts immediately to these values; no partial write is completed or retried.

Address mapping:
- off = ALU_result - BASE_ADDR, computed mod 2^32.
- word = off[SRAM_AW:2], truncated.
- low half at {word,1'b0}, high half at {word,1'b1}.
- off[1:0] ignored (word-aligned only).

FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: ready = ~(MEM_R_EN|MEM_W_EN), combinational.
  - On a request, register op (write if MEM_W_EN, else read), address and Val_Rm; go to LOW with counter=0.
  - Both enables high: write wins.
- LOW: SRAM_ADDR = low half address.
  - Write: SRAM_WE_N=0, SRAM_DQ_oe=1, SRAM_DQ_out=data[15:0].
  - Stay ACCESS_CYCLES cycles. Read: on the last cycle, capture SRAM_DQ_in into read_data[15:0].
  - Then go to HIGH, counter=0.
- HIGH: same as LOW with the high half address and data[31:16] / read_data[31:16]; then go to DONE.
- DONE: SRAM_WE_N=1, SRAM_DQ_oe=0, ready=1 for exactly one cycle; go to IDLE.
  - Request inputs are ignored in DONE; the pipeline advances at this edge.

Pin and output timing:
- SRAM_WE_N, SRAM_DQ_oe and SRAM_ADDR are registered outputs.
- SRAM_WE_N is deasserted for at least one cycle between the two halves: WE_N=1 on the first cycle of HIGH, then low for the remaining ACCESS_CYCLES-1 cycles.
  - With ACCESS_CYCLES=1 the HIGH half gets one extra cycle instead.
- Latency: request first seen in cycle 0 gives ready=1 in cycle 2*ACCESS_CYCLES+1, or +2 if ACCESS_CYCLES=1.
- read_data holds its value until the next load; stores do not modify it.
- Back-to-back requests: the IDLE cycle after DONE samples the new request, so there is one ready=0 cycle minimum.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE,LOW,HIGH,DONE};
  - BASE_ADDR default constant;
  - function map_addr(byte_addr) returning the SRAM word index.
- One natural sub-module: sram_half_seq, the per-half counter that produces the last-cycle strobe and WE_N pulse shaping, instantiated once and reused for both halves.

Test Plan:
- Store: MEM_W_EN=1, ALU_result=1032, Val_Rm=0xDEADBEEF, ACCESS_CYCLES=2 -> SRAM_ADDR=4 with DQ=0xBEEF, then SRAM_ADDR=5 with DQ=0xDEAD; WE_N gap between halves; ready=1 in cycle 5.
- Load: behavioural SRAM model preloaded from the store above, MEM_R_EN=1, ALU_result=1032 -> read_data=0xDEADBEEF with ready=1 in cycle 5; SRAM_DQ_oe=0 throughout.
- Idle pipeline: no enables for 10 cycles -> ready=1 constantly, WE_N=1, oe=0.
- Conflicting request: MEM_R_EN=MEM_W_EN=1, Val_Rm=0x12345678, ALU_result=1024 -> write to SRAM_ADDR 0/1; read_data unchanged.
- Reset mid-op: assert rst in the first LOW cycle of a store -> same-cycle WE_N=1, oe=0, ready reflects IDLE; SRAM_ADDR 1 never written.
- Back-to-back: store 1036/0xA5A55A5A immediately followed by load 1036 -> read_data=0xA5A55A5A; exactly one ready=1 cycle per access.
